// File: rtl/jtframe_shram_arb.sv
// Shared single-port RAM with an arbiter for up to four CPU channels.
// Each channel gets a wait_n stall until its grant is established and the
// registered RAM output matches its current address. Once a channel owns
// the RAM it keeps it for as long as it holds cs.
module jtframe_shram_arb #(
  parameter int NCH = 2,
  parameter int AW  = 13,
  parameter int DW  = 8,
  parameter int RR  = 0
) (
  input  logic              rst,
  input  logic              clk24,
  input  logic [NCH-1:0]    cs,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] din,
  output logic [NCH*DW-1:0] dout,
  output logic [NCH-1:0]    wait_n,
  output logic [NCH-1:0]    grant
);

  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t          state;
  logic [LW-1:0]   last_owner;
  logic            ready_q;
  logic [AW-1:0]   rd_addr_q;
  logic [DW-1:0]   ram_q;
  logic [DW-1:0]   mem [0:(1<<AW)-1];

  logic            win_found;
  logic [LW-1:0]   win_idx;
  logic [NCH-1:0]  win_onehot;
  logic            owner_keeps;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic            ram_we;
  logic            ready;

  // Winner search: fixed mode scans from channel 0; round-robin mode scans
  // from the channel after the last owner.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (RR != 0) ? ((int'(last_owner) + 1 + k) % NCH) : k;
      if (!win_found && cs[idx]) begin
        win_found = 1'b1;
        win_idx   = LW'(idx);
      end
    end
  end

  assign win_onehot  = NCH'(1) << win_idx;
  assign owner_keeps = |(grant & cs);

  // RAM port mux: only the granted channel drives the RAM; with no grant
  // nothing is written.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        ram_addr = addr[i*AW +: AW];
        ram_din  = din[i*DW +: DW];
        ram_we   = cs[i] & we[i];
      end
    end
  end

  // The RAM output is valid for the owner once the grant has settled and
  // the address it was read with is still the one the owner presents.
  assign ready  = ready_q & (ram_addr == rd_addr_q);
  assign wait_n = ~cs | (grant & {NCH{ready}});

  // Arbiter FSM: grant, last owner and ready flag are all registered here.
  always_ff @(posedge clk24 or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      ready_q    <= 1'b0;
      last_owner <= LW'(NCH-1);
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (win_found) begin
            state      <= ST_OWNED;
            grant      <= win_onehot;
            last_owner <= win_idx;
          end
        end
        ST_OWNED: begin
          if (owner_keeps) begin
            ready_q <= 1'b1;
          end else if (win_found) begin
            grant      <= win_onehot;
            last_owner <= win_idx;
            ready_q    <= 1'b0;
          end else begin
            state   <= ST_IDLE;
            grant   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Single-port RAM with write-first read data, so a read that follows a
  // write to the same word returns the new data.
  always_ff @(posedge clk24) begin
    // NOTE: the RAM array and its output register have no reset; contents survive rst and map onto block RAM.
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_q         <= ram_din;
    end else begin
      ram_q <= mem[ram_addr];
    end
  end

  // Remember which address the RAM output corresponds to.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) rd_addr_q <= '0;
    else     rd_addr_q <= ram_addr;
  end

  // Per-channel read data: loaded only when the owner's data is valid.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (grant[i] && ready && cs[i]) dout[i*DW +: DW] <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_shram_arb.sv
// Bench for jtframe_shram_arb: a fixed-priority two-channel instance driven
// from a vector table, and a three-channel round-robin instance driven by
// hand-written sequences for rotation and mid-access reset.
module tb_jtframe_shram_arb;

  logic clk24 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk24 = ~clk24;

  // Fixed-priority instance (NCH=2, RR=0)
  logic [1:0]  f_cs, f_we, f_wait_n, f_grant;
  logic [25:0] f_addr;
  logic [15:0] f_din, f_dout;

  jtframe_shram_arb #(.NCH(2), .AW(13), .DW(8), .RR(0)) u_fix (
    .rst(rst), .clk24(clk24), .cs(f_cs), .we(f_we), .addr(f_addr),
    .din(f_din), .dout(f_dout), .wait_n(f_wait_n), .grant(f_grant)
  );

  // Round-robin instance (NCH=3, RR=1)
  logic [2:0]  r_cs, r_we, r_wait_n, r_grant;
  logic [38:0] r_addr;
  logic [23:0] r_din, r_dout;

  jtframe_shram_arb #(.NCH(3), .AW(13), .DW(8), .RR(1)) u_rr (
    .rst(rst), .clk24(clk24), .cs(r_cs), .we(r_we), .addr(r_addr),
    .din(r_din), .dout(r_dout), .wait_n(r_wait_n), .grant(r_grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  cs;
    logic [1:0]  we;
    logic [12:0] a0;
    logic [12:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [1:0]  wpre;   // wait_n after driving, before the edge
    logic [1:0]  g;      // grant after the edge
    logic [1:0]  wpost;  // wait_n after the edge
    logic [15:0] dout;   // {ch1, ch0} after the edge
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  logic [2:0] seq [4];

  initial begin
    // ch0 writes A5 to 1FFF, releases; ch1 reads it back (2 wait cycles)
    vt[0]  = '{2'b01, 2'b01, 13'h1FFF, 13'h0000, 8'hA5, 8'h00, 2'b10, 2'b01, 2'b10, 16'h0000};
    vt[1]  = '{2'b01, 2'b01, 13'h1FFF, 13'h0000, 8'hA5, 8'h00, 2'b10, 2'b01, 2'b11, 16'h0000};
    vt[2]  = '{2'b01, 2'b01, 13'h1FFF, 13'h0000, 8'hA5, 8'h00, 2'b11, 2'b01, 2'b11, 16'h00A5};
    vt[3]  = '{2'b10, 2'b00, 13'h1FFF, 13'h1FFF, 8'h00, 8'h00, 2'b01, 2'b10, 2'b01, 16'h00A5};
    vt[4]  = '{2'b10, 2'b00, 13'h1FFF, 13'h1FFF, 8'h00, 8'h00, 2'b01, 2'b10, 2'b11, 16'h00A5};
    vt[5]  = '{2'b10, 2'b00, 13'h1FFF, 13'h1FFF, 8'h00, 8'h00, 2'b11, 2'b10, 2'b11, 16'hA5A5};
    // ch1 stays owner: writes 11 @000 and 22 @001, then reads with address changes
    vt[6]  = '{2'b10, 2'b10, 13'h0000, 13'h0000, 8'h00, 8'h11, 2'b01, 2'b10, 2'b11, 16'hA5A5};
    vt[7]  = '{2'b10, 2'b10, 13'h0000, 13'h0001, 8'h00, 8'h22, 2'b01, 2'b10, 2'b11, 16'hA5A5};
    vt[8]  = '{2'b10, 2'b00, 13'h0000, 13'h0000, 8'h00, 8'h00, 2'b01, 2'b10, 2'b11, 16'hA5A5};
    vt[9]  = '{2'b10, 2'b00, 13'h0000, 13'h0000, 8'h00, 8'h00, 2'b11, 2'b10, 2'b11, 16'h11A5};
    vt[10] = '{2'b10, 2'b00, 13'h0000, 13'h0001, 8'h00, 8'h00, 2'b01, 2'b10, 2'b11, 16'h11A5};
    vt[11] = '{2'b10, 2'b00, 13'h0000, 13'h0001, 8'h00, 8'h00, 2'b11, 2'b10, 2'b11, 16'h22A5};
    vt[12] = '{2'b00, 2'b00, 13'h0000, 13'h0001, 8'h00, 8'h00, 2'b11, 2'b00, 2'b11, 16'h22A5};
    // both request on the same edge: ch0 wins, ch1 takes over as ch0 drops
    vt[13] = '{2'b11, 2'b01, 13'h0010, 13'h0001, 8'h5C, 8'h00, 2'b00, 2'b01, 2'b00, 16'h22A5};
    vt[14] = '{2'b11, 2'b01, 13'h0010, 13'h0001, 8'h5C, 8'h00, 2'b00, 2'b01, 2'b01, 16'h22A5};
    vt[15] = '{2'b11, 2'b01, 13'h0010, 13'h0001, 8'h5C, 8'h00, 2'b01, 2'b01, 2'b01, 16'h225C};
    vt[16] = '{2'b10, 2'b00, 13'h0010, 13'h0001, 8'h00, 8'h00, 2'b01, 2'b10, 2'b01, 16'h225C};
    vt[17] = '{2'b10, 2'b00, 13'h0010, 13'h0001, 8'h00, 8'h00, 2'b01, 2'b10, 2'b11, 16'h225C};
    vt[18] = '{2'b10, 2'b00, 13'h0010, 13'h0001, 8'h00, 8'h00, 2'b11, 2'b10, 2'b11, 16'h225C};
    vt[19] = '{2'b00, 2'b00, 13'h0010, 13'h0001, 8'h00, 8'h00, 2'b11, 2'b00, 2'b11, 16'h225C};

    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;

    f_cs = '0; f_we = '0; f_addr = '0; f_din = '0;
    r_cs = '0; r_we = '0; r_addr = '0; r_din = '0;

    // Reset state
    repeat (2) @(posedge clk24);
    #1;
    f_cs = 2'b01;
    #1;
    check("rst_f_grant", 32'(f_grant), 32'h0);
    check("rst_f_dout", 32'(f_dout), 32'h0);
    check("rst_f_wait_n", 32'(f_wait_n), 32'h2);
    check("rst_r_grant", 32'(r_grant), 32'h0);
    f_cs = '0;
    @(negedge clk24);
    rst = 1'b0;

    // Table-driven vectors on the fixed-priority instance
    for (int i = 0; i < NV; i++) begin
      f_cs   = vt[i].cs;
      f_we   = vt[i].we;
      f_addr = {vt[i].a1, vt[i].a0};
      f_din  = {vt[i].d1, vt[i].d0};
      #1;
      check($sformatf("v%0d_wait_pre", i), 32'(f_wait_n), 32'(vt[i].wpre));
      @(posedge clk24);
      #1;
      check($sformatf("v%0d_grant", i), 32'(f_grant), 32'(vt[i].g));
      check($sformatf("v%0d_wait_post", i), 32'(f_wait_n), 32'(vt[i].wpost));
      check($sformatf("v%0d_dout", i), 32'(f_dout), 32'(vt[i].dout));
    end

    // Round-robin rotation with all channels requesting
    r_cs = 3'b111;
    @(posedge clk24);
    #1;
    check("rr_grant_first", 32'(r_grant), 32'(seq[0]));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk24);
      #1;
      check($sformatf("rr_wait_n_%0d", k), 32'(r_wait_n), 32'(seq[k]));
      @(posedge clk24);
      #1;
      r_cs = 3'b111 & ~seq[k];
      @(posedge clk24);
      #1;
      check($sformatf("rr_grant_%0d", k + 1), 32'(r_grant), 32'(seq[k + 1]));
      r_cs = 3'b111;
    end

    // Release, then ch0 stores 3C at 0AA
    r_cs = 3'b000;
    @(posedge clk24);
    #1;
    check("rr_idle", 32'(r_grant), 32'h0);
    r_cs = 3'b001; r_we = 3'b001;
    r_addr[0 +: 13] = 13'h00AA; r_din[0 +: 8] = 8'h3C;
    repeat (3) @(posedge clk24);
    #1;
    check("rr_wr_dout0", 32'(r_dout[7:0]), 32'h3C);
    r_cs = 3'b000; r_we = 3'b000;
    @(posedge clk24);
    #1;

    // ch1 gains ownership with a write pending, then reset aborts it
    r_cs = 3'b010; r_we = 3'b010;
    r_addr[13 +: 13] = 13'h00AA; r_din[8 +: 8] = 8'hC3;
    @(posedge clk24);
    #1;
    check("rr_ch1_grant", 32'(r_grant), 32'h2);
    rst = 1'b1;
    #1;
    check("rr_rst_grant", 32'(r_grant), 32'h0);
    check("rr_rst_dout", 32'(r_dout), 32'h0);
    check("rr_rst_wait_n", 32'(r_wait_n), 32'h5);
    repeat (2) @(posedge clk24);
    @(negedge clk24);
    rst = 1'b0;
    r_cs = 3'b011; r_we = 3'b000;
    @(posedge clk24);
    #1;
    check("rr_post_rst_grant", 32'(r_grant), 32'h1);
    repeat (2) @(posedge clk24);
    #1;
    check("rr_word_kept", 32'(r_dout[7:0]), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
